clk_divider_bank: RTL and testbench
===================================

# clk_divider_bank

Parametrised bank of NUM_CH independent clock dividers sharing one system clock, each with a runtime-programmable divisor, enable, and phase-alignment clear. Each channel produces a 50%-duty toggled divided clock and a one-cycle tick strobe at the terminal count. It replaces single fixed-divisor dividers in the display and game-timing paths, for example digit scan, blink and frame ticks, with one configurable block.

## Interface
- NUM_CH, 4: number of divider channels (1..16)
- DIV_W, 32: divisor and counter width in bits
- DEFAULT_DIV, 4999: divisor loaded into every channel at reset
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel count enable
- sync_clr  in  1  synchronous clear of all counters and div_clk outputs
- cfg_we  in  1  divisor write strobe, sampled on the rising edge of clk
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel selected by cfg_we
- cfg_div  in  DIV_W  new divisor value D
- div_clk  out  NUM_CH  divided clocks, period 2·(D+1) clk cycles
- tick  out  NUM_CH  one-cycle strobe at each terminal count, period D+1 clk cycles

## Operation
- Per channel: counter cnt (DIV_W bits), active divisor div, output flop dclk.
- With en=1:
  - If cnt==div: cnt←0, dclk←~dclk, tick=1 for that cycle.
  - Otherwise cnt←cnt+1, tick=0.
- D=0: dclk toggles every cycle and tick stays high continuously.
- With en=0: cnt and dclk hold and tick=0. When en is reasserted, counting resumes from the held count with no phase loss.
- sync_clr=1: every channel gets cnt←0, dclk←0, tick=0, regardless of en. Divisors are unaffected.
- cfg_we=1 writes cfg_div to channel cfg_ch.
  - If cfg_ch≥NUM_CH, the write is ignored.
  - Application timing depends on CLKDIV_SHADOW_EN (see Configuration).
- Priority per channel: sync_clr > divisor write effects > normal counting.
- Comparison is equality only. A non-shadowed write of a divisor smaller than the current cnt is handled by the counter clear described under Configuration; the counter never wraps through 2^DIV_W.
- Reset (rst_n=0, asynchronous): cnt=0, div=DEFAULT_DIV, dclk=0, tick=0, shadow register=DEFAULT_DIV, pending flag=0.

## Timing
- tick is registered. It is asserted in the cycle after the edge on which cnt==div was sampled, coincident with the dclk transition.
- The first tick after reset or sync_clr occurs D+1 enabled cycles after the clear releases.
- Divisor write latency:
  - Without shadowing: the new div is used from the next edge.
  - With shadowing: the new div is used from the cycle after the next terminal count.
- Reset deasserts asynchronously. The first count occurs on the first clk edge with rst_n=1 and en=1.
- Simultaneous cfg_we and terminal count on the same channel, shadow mode: the terminal count completes with the old div, and the new div is loaded into div on that same edge.
- Simultaneous sync_clr and cfg_we: the write is still captured, and the clear is applied.

## Configuration
- Macro: CLKDIV_SHADOW_EN.
- Defined:
  - The write goes to a per-channel shadow register and sets a pending flag.
  - At the next terminal count, div←shadow and pending←0.
  - Output periods never have a truncated or stretched half-cycle.
  - If several writes arrive before the terminal count, the last write wins.
  - While pending=1, sync_clr also transfers shadow→div.
- Undefined:
  - The write sets div←cfg_div and cnt←0 on the same edge.
  - dclk holds its level.
  - The next toggle occurs cfg_div+1 cycles later.

## Structure
- Package clkdiv_pkg:
  - Parameter defaults: DEFAULT_DIV, DIV_W, max NUM_CH.
  - Function div_for_hz(clk_hz, hz) = clk_hz/(2·hz) − 1, used by integrators to compute divisors.
  - Typedef of the channel-index type.
- Sub-module clkdiv_channel holds cnt, div, dclk, tick, and the optional shadow/pending logic. It is instantiated NUM_CH times in a generate loop.
- The top level contains only write-address decode and output concatenation.

## Test plan
- Reset with DEFAULT_DIV=4, en=all 1: div_clk[0] rises at cycle 5 and falls at cycle 10 (period 10); tick high on cycles 5, 10, 15.
- cfg_div=0 on ch1 with shadow undefined: from the following cycle div_clk[1] toggles every clk and tick[1] stays high.
- Shadow defined, ch0 D=9 at cnt=3, write D=2: the current half-period still lasts 10 cycles; subsequent half-periods last 3 cycles.
- en[2] dropped for 7 cycles mid-count: div_clk[2] and cnt hold, tick[2]=0, and the half-period is stretched by exactly 7 cycles.
- Channels set to D=3, 5 and 7, then sync_clr pulsed: all div_clk=0 the next cycle; the first ticks follow at 4, 6 and 8 cycles after release.
- cfg_ch=NUM_CH (NUM_CH=3, out of range): no channel's divisor changes. Assert rst_n low mid-count: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants, channel-index type and divisor helper for the clk_divider_bank family.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_DIV_W       = 32;
  localparam int unsigned CLKDIV_DEFAULT_DIV = 4999;
  localparam int unsigned CLKDIV_MAX_CH      = 16;

  typedef logic [$clog2(CLKDIV_MAX_CH)-1:0] ch_idx_t;

  // Divisor that makes div_clk run at hz when the system clock runs at clk_hz.
  function automatic logic [CLKDIV_DIV_W-1:0] div_for_hz(input longint unsigned clk_hz,
                                                         input longint unsigned hz);
    return CLKDIV_DIV_W'(clk_hz / (2 * hz) - 1);
  endfunction

endpackage : clkdiv_pkg

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active divisor, toggled 50% clock and terminal-count tick.
// Defining CLKDIV_SHADOW_EN defers divisor writes to the next terminal count via a shadow register.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned      DIV_W       = CLKDIV_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLKDIV_DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [DIV_W-1:0] wdata_i,
  output logic             div_clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             dclk_q, dclk_d;
  logic             tick_q, tick_d;
  logic             terminal;
`ifdef CLKDIV_SHADOW_EN
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
`endif

  assign terminal = en_i && (cnt_q == div_q);

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through this block infers a latch.
    cnt_d  = cnt_q;
    div_d  = div_q;
    dclk_d = dclk_q;
    tick_d = 1'b0;
`ifdef CLKDIV_SHADOW_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
`endif

    if (clr_i) begin
      cnt_d  = '0;
      dclk_d = 1'b0;
    end else if (terminal) begin
      cnt_d  = '0;
      dclk_d = ~dclk_q;
      tick_d = 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end

`ifdef CLKDIV_SHADOW_EN
    // The counter restarts from zero on a clear or terminal edge, so only then may div change.
    if (clr_i || terminal) begin
      if (we_i) begin
        div_d    = wdata_i;
        shadow_d = wdata_i;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        div_d  = shadow_q;
        pend_d = 1'b0;
      end
    end else if (we_i) begin
      shadow_d = wdata_i;
      pend_d   = 1'b1;
    end
`else
    // An immediate write restarts the count so cnt can never sit above a smaller new div.
    if (we_i) begin
      div_d = wdata_i;
      if (!clr_i) begin
        cnt_d  = '0;
        dclk_d = dclk_q;
        tick_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DEFAULT_DIV;
      dclk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      dclk_q <= dclk_d;
      tick_q <= tick_d;
    end
  end

`ifdef CLKDIV_SHADOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DEFAULT_DIV;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end
`endif

  assign div_clk_o = dclk_q;
  assign tick_o    = tick_q;

endmodule : clkdiv_channel

// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers: write-address decode and output concatenation.
// Optional feature macro: CLKDIV_SHADOW_EN (shadowed divisor writes, applied at the next terminal count).
module clk_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      DIV_W       = CLKDIV_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLKDIV_DEFAULT_DIV),
  localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);

  // Indices at or above NUM_CH match no channel, so such writes fall away.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en[i]),
      .clr_i    (sync_clr),
      .we_i     (we_ch),
      .wdata_i  (cfg_div),
      .div_clk_o(div_clk[i]),
      .tick_o   (tick[i])
    );
  end

endmodule : clk_divider_bank

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: NUM_CH=3, DIV_W=16, DEFAULT_DIV=4.
module tb_clk_divider_bank;

  logic        clk;
  logic        rst_n;
  logic [2:0]  en;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [2:0]  div_clk;
  logic [2:0]  tick;

  int checks = 0;
  int errors = 0;
  int first_tick [3];

  typedef struct {
    logic [2:0] en;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
  } vec_t;

  vec_t vecs [19];

  clk_divider_bank #(
    .NUM_CH     (3),
    .DIV_W      (16),
    .DEFAULT_DIV(16'd4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .div_clk (div_clk),
    .tick    (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = 16'(d);
    cyc();
    cfg_we  = 1'b0;
  endtask

  task automatic pulse_clr();
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
  endtask

  task automatic wait_toggle(input int ch, output int n);
    logic start;
    start = div_clk[ch];
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      cyc();
      if (div_clk[ch] != start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic find_first_ticks(input int limit);
    for (int c = 0; c < 3; c++) first_tick[c] = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      for (int c = 0; c < 3; c++)
        if (tick[c] && first_tick[c] < 0) first_tick[c] = i;
    end
  endtask

  initial begin
    int n;
    logic prev;
    bit found;

    vecs = '{
      '{3'b111, 3'b000, 3'b000},  // 1
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b111, 3'b111},  // 5: first toggle and tick
      '{3'b111, 3'b111, 3'b000},
      '{3'b111, 3'b111, 3'b000},
      '{3'b111, 3'b111, 3'b000},
      '{3'b111, 3'b111, 3'b000},
      '{3'b111, 3'b000, 3'b111},  // 10
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b000, 3'b000},
      '{3'b111, 3'b111, 3'b111},  // 15
      '{3'b000, 3'b111, 3'b000},  // disabled: hold, no tick
      '{3'b000, 3'b111, 3'b000},
      '{3'b000, 3'b111, 3'b000},
      '{3'b111, 3'b111, 3'b000}   // resume from held count
    };

    rst_n    = 1'b0;
    en       = 3'b000;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 2'd0;
    cfg_div  = 16'd0;

    #22;
    check("reset_div_clk", div_clk, 0);
    check("reset_tick", tick, 0);
    rst_n = 1'b1;

    // Default divisor 4 on all channels, then an enable gap.
    for (int k = 0; k < 19; k++) begin
      en = vecs[k].en;
      cyc();
      check($sformatf("vec%0d_div_clk", k + 1), div_clk, vecs[k].exp_clk);
      check($sformatf("vec%0d_tick", k + 1), tick, vecs[k].exp_tick);
    end

    // D = 3, 5, 7 then sync_clr: first ticks 4, 6, 8 cycles after release.
    cfg_write(0, 3);
    cfg_write(1, 5);
    cfg_write(2, 7);
    pulse_clr();
    check("clr_div_clk", div_clk, 0);
    check("clr_tick", tick, 0);
    find_first_ticks(12);
    check("clr_first_tick_ch0", first_tick[0], 4);
    check("clr_first_tick_ch1", first_tick[1], 6);
    check("clr_first_tick_ch2", first_tick[2], 8);

    // en[2] dropped for 7 cycles after 3 counted cycles: half-period 8 becomes 15.
    pulse_clr();
    repeat (3) cyc();
    en = 3'b011;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("hold_div_clk2", div_clk[2], 0);
      check("hold_tick2", tick[2], 0);
    end
    en = 3'b111;
    wait_toggle(2, n);
    check("hold_half_period_ch2", 3 + 7 + n, 15);

    // Out-of-range channel write must leave all divisors untouched.
    cfg_write(3, 1);
    pulse_clr();
    find_first_ticks(12);
    check("oor_first_tick_ch0", first_tick[0], 4);
    check("oor_first_tick_ch1", first_tick[1], 6);
    check("oor_first_tick_ch2", first_tick[2], 8);

`ifdef CLKDIV_SHADOW_EN
    // ch0: D=9, write D=2 at cnt=3; current half-period stays 10, later ones are 3.
    cfg_write(0, 9);
    pulse_clr();
    repeat (3) cyc();
    cfg_write(0, 2);
    wait_toggle(0, n);
    check("shadow_current_half", 4 + n, 10);
    wait_toggle(0, n);
    check("shadow_next_half_1", n, 3);
    wait_toggle(0, n);
    check("shadow_next_half_2", n, 3);
`else
    // ch0 D=3 with dclk high at cnt=2: write D=2 keeps level, next toggle after 3 cycles.
    pulse_clr();
    repeat (4) cyc();
    check("imm_pre_level", div_clk[0], 1);
    repeat (2) cyc();
    cfg_write(0, 2);
    check("imm_level_held", div_clk[0], 1);
    wait_toggle(0, n);
    check("imm_first_toggle", n, 3);
    wait_toggle(0, n);
    check("imm_second_toggle", n, 3);

    // ch1 D=0: toggles every cycle with tick held high.
    cfg_write(1, 0);
    for (int i = 0; i < 6; i++) begin
      prev = div_clk[1];
      cyc();
      check("d0_toggle_ch1", div_clk[1], !prev);
      check("d0_tick_ch1", tick[1], 1);
    end
`endif

    // Asynchronous reset mid-count: outputs clear without a clock edge.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (div_clk != 3'b000) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("pre_reset_active", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_div_clk", div_clk, 0);
    check("async_reset_tick", tick, 0);
    rst_n = 1'b1;

    // Divisors return to DEFAULT_DIV=4: first tick 5 cycles after release.
    find_first_ticks(8);
    check("post_reset_tick_ch0", first_tick[0], 5);
    check("post_reset_tick_ch1", first_tick[1], 5);
    check("post_reset_tick_ch2", first_tick[2], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clk_divider_bank
